// File: rtl/press_decoder.sv
// Classifies debounced press bursts as single/double (and triple when
// PRESS_DECODER_TRIPLE_EN is defined) presses; keeps a saturating press count.
module press_decoder #(
    parameter int WINDOW_CYCLES = 1250000,
    parameter int TIMER_W       = 21,
    parameter int COUNT_W       = 8
) (
    input  logic               clk5,
    input  logic               reset,
    input  logic               clean,
    output logic               single_press,
    output logic               double_press,
`ifdef PRESS_DECODER_TRIPLE_EN
    output logic               triple_press,
`endif
    output logic               busy,
    output logic [COUNT_W-1:0] press_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT2 = 2'd1,
        WAIT3 = 2'd2
    } state_t;

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(WINDOW_CYCLES - 1);

    state_t               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 clean_d_q;
    logic                 single_q, single_d;
    logic                 double_q, double_d;
    logic                 busy_q, busy_d;
    logic [COUNT_W-1:0]   count_q, count_d;
`ifdef PRESS_DECODER_TRIPLE_EN
    logic                 triple_q, triple_d;
`endif

    logic ev;
    assign ev = clean & ~clean_d_q;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        single_d = 1'b0;
        double_d = 1'b0;
`ifdef PRESS_DECODER_TRIPLE_EN
        triple_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (ev) begin
                    state_d = WAIT2;
                    timer_d = '0;
                end
            end
            WAIT2: begin
                timer_d = timer_q + 1'b1;
                // A press in the terminal cycle still merges into the burst.
                if (ev) begin
`ifdef PRESS_DECODER_TRIPLE_EN
                    state_d = WAIT3;
                    timer_d = '0;
`else
                    state_d  = IDLE;
                    double_d = 1'b1;
`endif
                end else if (timer_q == TIMER_LAST) begin
                    state_d  = IDLE;
                    single_d = 1'b1;
                end
            end
`ifdef PRESS_DECODER_TRIPLE_EN
            WAIT3: begin
                timer_d = timer_q + 1'b1;
                if (ev) begin
                    state_d  = IDLE;
                    triple_d = 1'b1;
                end else if (timer_q == TIMER_LAST) begin
                    state_d  = IDLE;
                    double_d = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        busy_d  = (state_d != IDLE);
        count_d = count_q;
        if (ev && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk5 or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            clean_d_q <= 1'b0;
            single_q  <= 1'b0;
            double_q  <= 1'b0;
            busy_q    <= 1'b0;
            count_q   <= '0;
`ifdef PRESS_DECODER_TRIPLE_EN
            triple_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            clean_d_q <= clean;
            single_q  <= single_d;
            double_q  <= double_d;
            busy_q    <= busy_d;
            count_q   <= count_d;
`ifdef PRESS_DECODER_TRIPLE_EN
            triple_q  <= triple_d;
`endif
        end
    end

    assign single_press = single_q;
    assign double_press = double_q;
    assign busy         = busy_q;
    assign press_count  = count_q;
`ifdef PRESS_DECODER_TRIPLE_EN
    assign triple_press = triple_q;
`endif

endmodule

// File: tb/tb_press_decoder.sv
// Self-checking bench for press_decoder: directed scenarios plus random bursts,
// compared every cycle against a deadline-based burst model.
module tb_press_decoder;

    localparam int W       = 10;
    localparam int COUNT_W = 4;
    localparam int CMAX    = (1 << COUNT_W) - 1;
`ifdef PRESS_DECODER_TRIPLE_EN
    localparam int MAXP = 3;
`else
    localparam int MAXP = 2;
`endif

    logic               clk5;
    logic               reset;
    logic               clean;
    logic               single_press;
    logic               double_press;
    logic               triple_obs;
    logic               busy;
    logic [COUNT_W-1:0] press_count;

    press_decoder #(
        .WINDOW_CYCLES(W),
        .TIMER_W      (4),
        .COUNT_W      (COUNT_W)
    ) dut (
        .clk5        (clk5),
        .reset       (reset),
        .clean       (clean),
        .single_press(single_press),
        .double_press(double_press),
`ifdef PRESS_DECODER_TRIPLE_EN
        .triple_press(triple_obs),
`endif
        .busy        (busy),
        .press_count (press_count)
    );

`ifndef PRESS_DECODER_TRIPLE_EN
    assign triple_obs = 1'b0;
`endif

    initial clk5 = 1'b0;
    always #5 clk5 = ~clk5;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a burst is open until its deadline cycle, a new
    // press inside the window extends or closes it depending on press count.
    int  t          = 0;
    bit  m_prev     = 0;
    bit  m_open     = 0;
    int  m_presses  = 0;
    int  m_deadline = 0;
    bit  e_single   = 0;
    bit  e_double   = 0;
    bit  e_triple   = 0;
    bit  e_busy     = 0;
    int  e_count    = 0;
    int  n_pulses   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, t);
        end
    endtask

    task automatic emit(input int presses);
        if (presses == 1) e_single = 1;
        else if (presses == 2) e_double = 1;
        else e_triple = 1;
        n_pulses++;
    endtask

    task automatic model_reset();
        m_prev = 0; m_open = 0; m_presses = 0;
        e_single = 0; e_double = 0; e_triple = 0; e_busy = 0; e_count = 0;
    endtask

    task automatic check_outputs();
        check("single_press", int'(single_press), int'(e_single));
        check("double_press", int'(double_press), int'(e_double));
        check("triple_press", int'(triple_obs), int'(e_triple));
        check("busy", int'(busy), int'(e_busy));
        check("press_count", int'(press_count), e_count);
    endtask

    // Drive one cycle of clean, advance the model, check after the edge.
    task automatic step(input bit c);
        bit ev;
        clean = c;
        ev = c && !m_prev;
        m_prev = c;
        e_single = 0; e_double = 0; e_triple = 0;
        if (m_open) begin
            if (ev) begin
                m_presses++;
                if (m_presses == MAXP) begin
                    emit(m_presses);
                    m_open = 0;
                end else begin
                    m_deadline = t + W;
                end
            end else if (t == m_deadline) begin
                emit(m_presses);
                m_open = 0;
            end
        end else if (ev) begin
            m_open = 1;
            m_presses = 1;
            m_deadline = t + W;
        end
        e_busy = m_open;
        if (ev && e_count < CMAX) e_count++;
        t++;
        @(negedge clk5);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    task automatic press(input int len);
        for (int i = 0; i < len; i++) step(1'b1);
    endtask

    // Async reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk5);
        clean = 1'b0;
        @(negedge clk5);
        check_outputs();
        reset = 1'b0;
    endtask

    initial begin
        int pulses_before;
        reset = 1'b1;
        clean = 1'b0;
        repeat (3) @(negedge clk5);
        check_outputs();
        reset = 1'b0;

        // Lone press -> single after the window.
        idle(4); press(1); idle(15);
        check("count_after_single", int'(press_count), 1);
        do_reset();

        // Two presses inside the window.
        idle(4); press(1); idle(6); press(1); idle(15);
        do_reset();

        // Second press in the terminal cycle, then one cycle too late.
        idle(4); press(1); idle(W - 1); press(1); idle(15);
        do_reset();
        idle(4); press(1); idle(W); press(1); idle(15);
        do_reset();

        // Held level is a single event.
        idle(4); press(4); idle(15);
        check("count_after_hold", int'(press_count), 1);
        do_reset();

        // Triple pattern (double then timeout when the feature is off).
        idle(4); press(1); idle(4); press(1); idle(3); press(1); idle(15);
        do_reset();
        idle(4); press(1); idle(4); press(1); idle(25);
        do_reset();

        // Abort mid-burst: no pulse may ever appear for it.
        idle(4); press(1); idle(3);
        pulses_before = n_pulses;
        do_reset();
        idle(20);
        check("abort_no_pulse", n_pulses, pulses_before);

        // Saturation.
        for (int i = 0; i < 20; i++) begin
            press(1); idle(W + 3);
        end
        check("count_saturated", int'(press_count), CMAX);
        do_reset();

        // Random bursts with gaps around the window edges.
        for (int i = 0; i < 120; i++) begin
            idle($urandom_range(0, 2 * W + 2));
            press($urandom_range(1, 3));
        end
        idle(3 * W);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
